// File: rtl/fir_filter_n.sv
// fir_filter_n: N-tap FIR filter core with a sample delay line and a coefficient bank.
// The coefficients are written one word at a time. Each accepted sample is filtered with
// one multiply-accumulate per cycle. Even taps add their product and odd taps subtract it.
//
// Ports:
//   clk             system clock, rising edge
//   n_reset         synchronous active-low reset
//   sample_data     unsigned sample, captured when data_ready is accepted in IDLE
//   fir_coefficient unsigned Q0.DATA_W coefficient word, captured on load_coeff in IDLE
//   load_coeff      one-cycle strobe: write the next coefficient slot (round-robin)
//   data_ready      one-cycle strobe: present a sample
//   modwait         high while a sample is being processed
//   fir_out         saturated magnitude of the last result
//   out_valid       one-cycle pulse when fir_out and err update
//   err             overflow / protocol-violation flag, sticky until a clean result
//   one_k_samples   one-cycle pulse every SAMPLE_TARGET results
module fir_filter_n #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned NUM_TAPS      = 4,
    parameter int unsigned SAMPLE_TARGET = 1000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    input  logic              data_ready,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              out_valid,
    output logic              err,
    output logic              one_k_samples
);

    // Wide enough that NUM_TAPS full-scale products can never wrap the signed accumulator.
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(NUM_TAPS) + 1;
    localparam int unsigned RES_W = ACC_W - DATA_W;
    localparam int unsigned TAP_W = $clog2(NUM_TAPS);
    localparam int unsigned CNT_W = $clog2(SAMPLE_TARGET + 1);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_TARGET - 1);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                    state_q, state_d;
    logic [DATA_W-1:0]         samp_q  [NUM_TAPS];
    logic [DATA_W-1:0]         samp_d  [NUM_TAPS];
    logic [DATA_W-1:0]         coeff_q [NUM_TAPS];
    logic [DATA_W-1:0]         coeff_d [NUM_TAPS];
    logic [TAP_W-1:0]          coeff_idx_q, coeff_idx_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         fir_out_q, fir_out_d;
    logic                      err_q, err_d;
    logic                      out_valid_q, out_valid_d;
    logic                      one_k_q, one_k_d;

    logic [2*DATA_W-1:0]       prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [RES_W-1:0]          res_raw;
    logic [RES_W-1:0]          res_mag;
    logic                      overflow;
    logic                      violation;

    // Product of the current tap, zero-extended so it is always treated as non-negative.
    always_comb begin
        prod     = {{DATA_W{1'b0}}, samp_q[tap_q]} * {{DATA_W{1'b0}}, coeff_q[tap_q]};
        prod_ext = signed'({{(ACC_W - 2 * DATA_W){1'b0}}, prod});
    end

    // Dropping the low DATA_W bits of the two's-complement accumulator rounds toward -inf.
    always_comb begin
        res_raw  = acc_q[ACC_W-1:DATA_W];
        res_mag  = res_raw[RES_W-1] ? (~res_raw + RES_W'(1)) : res_raw;
        overflow = |res_mag[RES_W-1:DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        coeff_d     = coeff_q;
        coeff_idx_d = coeff_idx_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        fir_out_d   = fir_out_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        one_k_d     = 1'b0;
        violation   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_coeff) begin
                    // A coefficient load wins over a simultaneous sample, which is dropped.
                    coeff_d[coeff_idx_q] = fir_coefficient;
                    coeff_idx_d = (coeff_idx_q == LAST_TAP) ? '0 : coeff_idx_q + TAP_W'(1);
                    violation   = data_ready;
                end else if (data_ready) begin
                    for (int k = int'(NUM_TAPS) - 1; k > 0; k--) begin
                        samp_d[k] = samp_q[k-1];
                    end
                    samp_d[0] = sample_data;
                    acc_d     = '0;
                    tap_d     = '0;
                    state_d   = StMac;
                end
            end
            StMac: begin
                violation = data_ready | load_coeff;
                acc_d     = tap_q[0] ? (acc_q - prod_ext) : (acc_q + prod_ext);
                if (tap_q == LAST_TAP) begin
                    state_d = StDone;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            StDone: begin
                violation   = data_ready | load_coeff;
                fir_out_d   = overflow ? '1 : res_mag[DATA_W-1:0];
                out_valid_d = 1'b1;
                state_d     = StIdle;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    one_k_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A result recomputes err; otherwise a violation sets it and nothing clears it.
        if (state_q == StDone) begin
            err_d = overflow | violation;
        end else if (violation) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            samp_q      <= '{default: '0};
            coeff_q     <= '{default: '0};
            coeff_idx_q <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            fir_out_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            one_k_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            coeff_q     <= coeff_d;
            coeff_idx_q <= coeff_idx_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            fir_out_q   <= fir_out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            one_k_q     <= one_k_d;
        end
    end

    assign modwait       = (state_q != StIdle);
    assign fir_out       = fir_out_q;
    assign out_valid     = out_valid_q;
    assign err           = err_q;
    assign one_k_samples = one_k_q;

endmodule

// File: tb/tb_fir_filter_n.sv
// Testbench for fir_filter_n (DATA_W=16, NUM_TAPS=4, SAMPLE_TARGET=3).
// A behavioural model predicts every output on every cycle from the sampled inputs.
// Directed scenarios also pin literal result values that were computed by hand.
module tb_fir_filter_n;

    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 4;
    localparam int TARGET   = 3;
    localparam longint MAXV = 65535;

    logic              clk = 1'b0;
    logic              n_reset;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] fir_coefficient;
    logic              load_coeff;
    logic              data_ready;
    logic              modwait;
    logic [DATA_W-1:0] fir_out;
    logic              out_valid;
    logic              err;
    logic              one_k_samples;

    fir_filter_n #(
        .DATA_W       (DATA_W),
        .NUM_TAPS     (NUM_TAPS),
        .SAMPLE_TARGET(TARGET)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .sample_data    (sample_data),
        .fir_coefficient(fir_coefficient),
        .load_coeff     (load_coeff),
        .data_ready     (data_ready),
        .modwait        (modwait),
        .fir_out        (fir_out),
        .out_valid      (out_valid),
        .err            (err),
        .one_k_samples  (one_k_samples)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy counts the cycles a sample occupies the filter; the result is computed
    // directly from the history and the coefficients when the sample is accepted.
    int                m_busy;
    longint            m_hist [NUM_TAPS];
    longint            m_coef [NUM_TAPS];
    int                m_idx;
    int                m_cnt;
    longint            m_res;
    logic              exp_modwait, exp_valid, exp_err, exp_onek;
    logic [DATA_W-1:0] exp_fir;

    task automatic model_step();
        bit     viol;
        longint sum;
        longint mag;
        if (!n_reset) begin
            m_busy = 0; m_idx = 0; m_cnt = 0; m_res = 0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                m_hist[k] = 0;
                m_coef[k] = 0;
            end
            exp_modwait = 0; exp_valid = 0; exp_err = 0; exp_onek = 0; exp_fir = '0;
            return;
        end
        exp_valid = 0;
        exp_onek  = 0;
        viol      = 0;
        if (m_busy == 0) begin
            if (load_coeff) begin
                m_coef[m_idx] = fir_coefficient;
                m_idx = (m_idx + 1) % NUM_TAPS;
                viol = data_ready;
            end else if (data_ready) begin
                for (int k = NUM_TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = sample_data;
                sum = 0;
                for (int t = 0; t < NUM_TAPS; t++) begin
                    if (t % 2 == 0) sum += m_hist[t] * m_coef[t];
                    else            sum -= m_hist[t] * m_coef[t];
                end
                m_res  = sum >>> DATA_W;
                m_busy = NUM_TAPS + 1;
            end
            if (viol) exp_err = 1;
        end else begin
            viol = data_ready || load_coeff;
            m_busy--;
            if (m_busy == 0) begin
                mag = (m_res < 0) ? -m_res : m_res;
                if (mag > MAXV) begin
                    exp_fir = '1;
                    exp_err = 1;
                end else begin
                    exp_fir = DATA_W'(mag);
                    exp_err = viol;
                end
                exp_valid = 1;
                m_cnt++;
                if (m_cnt == TARGET) begin
                    m_cnt    = 0;
                    exp_onek = 1;
                end
            end else if (viol) begin
                exp_err = 1;
            end
        end
        exp_modwait = (m_busy != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_modwait", modwait, exp_modwait);
            chk("cyc_out_valid", out_valid, exp_valid);
            chk("cyc_fir_out", fir_out, exp_fir);
            chk("cyc_err", err, exp_err);
            chk("cyc_one_k", one_k_samples, exp_onek);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic do_reset();
        n_reset = 1'b0;
        load_coeff = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        chk("rst_fir_out", fir_out, 0);
        chk("rst_outputs", {modwait, out_valid, err, one_k_samples}, 0);
        n_reset = 1'b1;
    endtask

    task automatic load(input logic [DATA_W-1:0] c);
        fir_coefficient = c;
        load_coeff = 1'b1;
        @(negedge clk);
        load_coeff = 1'b0;
    endtask

    task automatic wait_result(output logic [DATA_W-1:0] f, output logic e, output logic ok_k,
                               output int mw);
        bit ok = 0;
        mw = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1;
                break;
            end
            if (modwait === 1'b1) mw++;
            @(negedge clk);
        end
        chk("result_timeout", ok, 1);
        f    = fir_out;
        e    = err;
        ok_k = one_k_samples;
    endtask

    task automatic run_sample(input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] f,
                              output logic e, output logic k, output int mw);
        sample_data = d;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        wait_result(f, e, k, mw);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] f;
    logic              e;
    logic              k;
    int                mw;
    int                pulses;

    initial begin
        n_reset = 1'b0;
        sample_data = '0;
        fir_coefficient = '0;
        load_coeff = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;

        // 1: single tap at 0.5
        do_reset();
        load(16'h8000); load(16'h0000); load(16'h0000); load(16'h0000);
        run_sample(16'd100, f, e, k, mw);
        chk("t1_fir_out", f, 50);
        chk("t1_err", e, 0);
        chk("t1_modwait_cycles", mw, 5);

        // 2: alternating signs, all coefficients 0.5
        do_reset();
        repeat (4) load(16'h8000);
        run_sample(16'd1000, f, e, k, mw); chk("t2_r1", f, 500);
        run_sample(16'd2000, f, e, k, mw); chk("t2_r2", f, 500);
        run_sample(16'd3000, f, e, k, mw); chk("t2_r3", f, 1000);
        run_sample(16'd4000, f, e, k, mw); chk("t2_r4", f, 1000);

        // 3: negative result gives its magnitude
        do_reset();
        load(16'h8000); load(16'h8000); load(16'h0000); load(16'h0000);
        run_sample(16'd3000, f, e, k, mw); chk("t3_r1", f, 1500);
        run_sample(16'd1000, f, e, k, mw); chk("t3_neg", f, 1000); chk("t3_neg_err", e, 0);
        run_sample(16'd5000, f, e, k, mw); chk("t3_r3", f, 2000);

        // 4: overflow saturates and sets err, then a clean result clears it
        do_reset();
        load(16'hFFFF); load(16'h0000); load(16'hFFFF); load(16'h0000);
        run_sample(16'hFFFF, f, e, k, mw); chk("t4_r1", f, 16'hFFFE);
        run_sample(16'h0000, f, e, k, mw); chk("t4_r2", f, 0);
        run_sample(16'hFFFF, f, e, k, mw); chk("t4_sat", f, 16'hFFFF); chk("t4_ovf_err", e, 1);
        run_sample(16'h0000, f, e, k, mw); chk("t4_r4", f, 0); chk("t4_err_clear", e, 0);

        // 5: protocol violations
        do_reset();
        load(16'h8000); load(16'h8000); load(16'h0000); load(16'h0000);
        sample_data = 16'd100;
        data_ready = 1'b1;
        @(negedge clk);
        sample_data = 16'd999;           // strobe again while busy: must be dropped
        @(negedge clk);
        data_ready = 1'b0;
        chk("t5_busy_err", err, 1);
        wait_result(f, e, k, mw);
        chk("t5_r1", f, 50); chk("t5_r1_err", e, 0);
        run_sample(16'd200, f, e, k, mw);
        chk("t5_line_intact", f, 50);
        fir_coefficient = 16'h4000;      // both strobes in IDLE: coefficient wins
        sample_data = 16'd777;
        load_coeff = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        load_coeff = 1'b0;
        data_ready = 1'b0;
        chk("t5_both_modwait", modwait, 0);
        chk("t5_both_err", err, 1);
        chk("t5_both_fir_hold", fir_out, 50);
        load(16'h8000);                  // lands in slot 1 if the index advanced
        run_sample(16'd400, f, e, k, mw);
        chk("t5_idx_advanced", f, 0); chk("t5_err_clear", e, 0);

        // 6: sample-count pulse every 3 results, then reset mid-MAC
        do_reset();
        load(16'h8000); load(16'h0000); load(16'h0000); load(16'h0000);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            run_sample(DATA_W'(10 * (i + 1)), f, e, k, mw);
            chk("t6_one_k", k, (i == 2 || i == 5) ? 1 : 0);
            if (k === 1'b1) pulses++;
        end
        chk("t6_pulse_count", pulses, 2);
        sample_data = 16'd500;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        n_reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_modwait", modwait, 0);
        chk("t6_rst_outs", {fir_out, out_valid, err, one_k_samples}, 0);
        n_reset = 1'b1;
        repeat (6) @(negedge clk);       // any in-flight result must not appear
        run_sample(16'd1234, f, e, k, mw);
        chk("t6_coeffs_cleared", f, 0);

        cmp_en = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_filter_n.md
Name: fir_filter_n

Overview:
Parametrised N-tap FIR filter core for the sample-processing path. It keeps a NUM_TAPS-deep sample delay line and a coefficient bank loaded one word at a time. Each accepted sample is filtered with one multiply-accumulate per cycle using alternating add/subtract taps. The block outputs a saturated magnitude, an error flag, a result strobe, and a periodic sample-count pulse.

Parameters:
DATA_W, 16, width of samples, coefficients and fir_out; coefficients are unsigned Q0.DATA_W, i.e. value = word/2^DATA_W.
NUM_TAPS, 4, number of taps and coefficient registers; legal range is 2 or more.
SAMPLE_TARGET, 1000, number of completed results per one_k_samples pulse; legal range is 1 or more.

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  synchronous active-low reset
sample_data  in  DATA_W  unsigned sample, captured when data_ready is accepted
fir_coefficient  in  DATA_W  coefficient word, captured when load_coeff is accepted
load_coeff  in  1  one-cycle strobe; writes the coefficient
data_ready  in  1  one-cycle strobe; presents a sample
modwait  out  1  high while a sample is being processed
fir_out  out  DATA_W  magnitude of the last result, saturated
out_valid  out  1  one-cycle pulse when fir_out and err update
err  out  1  error flag
one_k_samples  out  1  one-cycle pulse every SAMPLE_TARGET results

Behaviour:
- Reset (n_reset=0 at a clk edge): state IDLE; delay line, coefficients, coeff_idx, accumulator and sample counter are cleared to 0. All outputs are 0. Reset takes priority at any state, including mid-MAC; any in-flight result is discarded.
- States: IDLE, MAC, DONE.
- IDLE, load_coeff=1: write coeff[coeff_idx] <= fir_coefficient. coeff_idx increments and wraps from NUM_TAPS-1 to 0. No other effect.
- IDLE, data_ready=1 and load_coeff=0 (accept edge E0):
  - shift the delay line: s[k] <= s[k-1], s[0] <= sample_data.
  - clear the accumulator, set tap index to 0, go to MAC, set modwait=1.
- MAC, edge Ei for i=1..NUM_TAPS, tap t=i-1:
  - acc <= acc + s[t]*c[t] for even t; acc <= acc - s[t]*c[t] for odd t.
  - After tap NUM_TAPS-1, go to DONE.
- DONE edge:
  - r = acc >>> DATA_W (arithmetic shift, truncation toward negative infinity).
  - fir_out <= min(|r|, 2^DATA_W-1).
  - err <= 1 if |r| > 2^DATA_W-1, else 0.
  - out_valid <= 1 for one cycle; modwait <= 0; increment the sample counter; go to IDLE.
- Timing: modwait is high for NUM_TAPS+1 cycles after E0. The next sample can be accepted on the first edge where modwait=0.
- Accumulator: signed, 2*DATA_W+$clog2(NUM_TAPS)+1 bits. The product is unsigned DATA_W x DATA_W, zero-extended. The accumulator never wraps internally.
- Sample counter:
  - On the DONE edge where the count reaches SAMPLE_TARGET, the counter returns to 0.
  - one_k_samples pulses for one cycle, coincident with out_valid.
  - The counter keeps running after the pulse.
- Protocol violations (input is ignored; err <= 1 at that edge; fir_out is unchanged):
  - data_ready=1 in MAC or DONE: the sample is dropped.
  - load_coeff=1 in MAC or DONE: the coefficient is dropped.
  - load_coeff=1 and data_ready=1 together in IDLE: the coefficient is written and the sample is dropped.
- A violation and a DONE edge in the same cycle: err <= 1 wins. fir_out and out_valid still update normally.
- err clearing: err stays set until the next DONE edge without overflow or violation, or until reset.
- Coefficients persist across samples until overwritten. The delay line persists until reset.

Test Plan:
1. DATA_W=16, NUM_TAPS=4. Load coeffs 0x8000, 0, 0, 0, then data_ready with sample 100 -> modwait high 5 cycles; out_valid pulse; fir_out=50; err=0.
2. Coeffs all 0x8000. Samples 1000, 2000, 3000, 4000, each sent after modwait falls -> 4th result fir_out=1000 (0.5*(4000-3000+2000-1000)).
3. Coeffs 0x8000, 0x8000, 0, 0. Samples 3000 then 1000 -> r=-1000, fir_out=1000, err=0. Then sample 5000 -> fir_out=2000.
4. Coeffs 0xFFFF, 0, 0xFFFF, 0. Samples 0xFFFF, 0, 0xFFFF -> third result overflows: fir_out=0xFFFF, err=1. Next sample 0 -> r=0, err=0.
5. Strobe data_ready during MAC -> sample dropped, err=1 next edge, delay line unchanged. Strobe load_coeff and data_ready together in IDLE -> coeff written, coeff_idx advances, err=1, modwait stays 0.
6. SAMPLE_TARGET=3: run 7 samples -> one_k_samples pulses with out_valid #3 and #6 only. Assert n_reset mid-MAC -> next edge all outputs 0, state IDLE, coefficients 0.
